// File: rtl/tx_sched.sv
// tx_sched: four one-entry order slots arbitrated round-robin onto one uart transmitter.
// Define TX_SCHED_DROPCNT_EN to add the per-requester saturating drop_cnt output.
module tx_sched #(
   parameter int BUSY_WAIT = 4,
   parameter int DROP_W    = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [7:0]          tx_addr0,
   input  logic [7:0]          tx_buysell0,
   input  logic [31:0]         tx_timestamp0,
   input  logic                tx_dv0,
   input  logic [7:0]          tx_addr1,
   input  logic [7:0]          tx_buysell1,
   input  logic [31:0]         tx_timestamp1,
   input  logic                tx_dv1,
   input  logic [7:0]          tx_addr2,
   input  logic [7:0]          tx_buysell2,
   input  logic [31:0]         tx_timestamp2,
   input  logic                tx_dv2,
   input  logic [7:0]          tx_addr3,
   input  logic [7:0]          tx_buysell3,
   input  logic [31:0]         tx_timestamp3,
   input  logic                tx_dv3,
   input  logic                tx_busy,
   output logic [7:0]          tx_addr,
   output logic [7:0]          tx_buysell,
   output logic [31:0]         tx_timestamp,
   output logic                tx_dv,
   output logic [3:0]          pending,
   output logic [1:0]          grant
`ifdef TX_SCHED_DROPCNT_EN
   ,
   output logic [4*DROP_W-1:0] drop_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

   typedef struct packed {
      logic [7:0]  addr;
      logic [7:0]  buysell;
      logic [31:0] timestamp;
   } order_t;

   localparam int                WCNT_W    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BUSY_WAIT - 1);

   order_t [3:0]      req_order;
   logic   [3:0]      req_dv;

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   order_t [3:0]      slot_q, slot_d;
   logic   [3:0]      valid_q, valid_d;
   logic   [1:0]      rr_ptr_q, rr_ptr_d;
   logic   [1:0]      grant_q, grant_d;
   order_t            out_q, out_d;
   logic              tx_dv_q, tx_dv_d;

   logic              pick_vld;
   logic   [1:0]      pick_idx;
   logic              issue;

   assign req_order[0] = {tx_addr0, tx_buysell0, tx_timestamp0};
   assign req_order[1] = {tx_addr1, tx_buysell1, tx_timestamp1};
   assign req_order[2] = {tx_addr2, tx_buysell2, tx_timestamp2};
   assign req_order[3] = {tx_addr3, tx_buysell3, tx_timestamp3};
   assign req_dv       = {tx_dv3, tx_dv2, tx_dv1, tx_dv0};

   // First valid slot scanning upward from rr_ptr, wrapping modulo 4.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = rr_ptr_q;
      for (int i = 0; i < 4; i++) begin
         if (!pick_vld && valid_q[rr_ptr_q + 2'(i)]) begin
            pick_vld = 1'b1;
            pick_idx = rr_ptr_q + 2'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!tx_busy && pick_vld) state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy)                       state_d = WAIT_DONE;
            else if (wait_cnt_q == WCNT_LAST)  state_d = IDLE;
         end
         WAIT_DONE: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      issue      = 1'b0;
      wait_cnt_d = '0;
      tx_dv_d    = 1'b0;
      out_d      = out_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         IDLE:      issue = !tx_busy && pick_vld;
         WAIT_BUSY: if (!tx_busy) wait_cnt_d = wait_cnt_q + WCNT_W'(1);
         default:   ;
      endcase
      if (issue) begin
         tx_dv_d  = 1'b1;
         out_d    = slot_q[pick_idx];
         grant_d  = pick_idx;
         rr_ptr_d = pick_idx + 2'd1;
      end
   end

   // The issued slot is freed before captures, so a same-edge order refills it without a drop.
   always_comb begin
      slot_d  = slot_q;
      valid_d = valid_q;
      if (issue) valid_d[pick_idx] = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (req_dv[n] && !valid_d[n]) begin
            slot_d[n]  = req_order[n];
            valid_d[n] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: slot payloads are reset too, so reset clears every slot, not just its valid bit.
         slot_q     <= '0;
         valid_q    <= '0;
         wait_cnt_q <= '0;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         out_q      <= '0;
         tx_dv_q    <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         valid_q    <= valid_d;
         wait_cnt_q <= wait_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         out_q      <= out_d;
         tx_dv_q    <= tx_dv_d;
      end
   end

`ifdef TX_SCHED_DROPCNT_EN
   logic [3:0][DROP_W-1:0] drop_q, drop_d;

   // A drop is an order arriving at a full slot that is not being issued on the same edge.
   always_comb begin
      drop_d = drop_q;
      for (int n = 0; n < 4; n++) begin
         if (req_dv[n] && valid_q[n] && !(issue && pick_idx == 2'(n)) && drop_q[n] != '1) begin
            drop_d[n] = drop_q[n] + DROP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`endif

   assign tx_addr      = out_q.addr;
   assign tx_buysell   = out_q.buysell;
   assign tx_timestamp = out_q.timestamp;
   assign tx_dv        = tx_dv_q;
   assign pending      = valid_q;
   assign grant        = grant_q;

   a_dv_single: assert property (@(posedge clk) disable iff (!reset_n) tx_dv_q |=> !tx_dv_q);
   a_issue_valid: assert property (@(posedge clk) disable iff (!reset_n) issue |-> valid_q[pick_idx]);

endmodule

// File: tb/tb_tx_sched.sv
// Self-checking bench for tx_sched: directed vector table, corner-case sequences and a
// randomized run against a transaction-level reference model with a simple uart responder.
module tb_tx_sched;
   localparam int BW       = 4;
   localparam int DW       = 8;
   localparam int DROP_MAX = (1 << DW) - 1;

   typedef struct packed {
      logic [7:0]  addr;
      logic [7:0]  bs;
      logic [31:0] ts;
   } order_t;

   typedef struct {
      int         req;
      order_t     ord;
      logic [3:0] exp_pend;
      logic [1:0] exp_grant;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset_n;
   order_t [3:0] in_ord;
   logic   [3:0] in_dv;
   logic         tx_busy;
   logic [7:0]   tx_addr;
   logic [7:0]   tx_buysell;
   logic [31:0]  tx_timestamp;
   logic         tx_dv;
   logic [3:0]   pending;
   logic [1:0]   grant;
`ifdef TX_SCHED_DROPCNT_EN
   logic [4*DW-1:0] drop_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: slots as arrays, link phase 0=free, 1=awaiting busy, 2=awaiting done.
   bit     model_on = 1'b0;
   order_t m_slot[4];
   bit     m_valid[4];
   int     m_drop[4];
   int     m_rr, m_mode, m_wait, m_grant;
   bit     m_dv;
   order_t m_out;

   int     u_rise, u_hold;

   tx_sched #(.BUSY_WAIT(BW), .DROP_W(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .tx_addr0(in_ord[0].addr), .tx_buysell0(in_ord[0].bs), .tx_timestamp0(in_ord[0].ts), .tx_dv0(in_dv[0]),
      .tx_addr1(in_ord[1].addr), .tx_buysell1(in_ord[1].bs), .tx_timestamp1(in_ord[1].ts), .tx_dv1(in_dv[1]),
      .tx_addr2(in_ord[2].addr), .tx_buysell2(in_ord[2].bs), .tx_timestamp2(in_ord[2].ts), .tx_dv2(in_dv[2]),
      .tx_addr3(in_ord[3].addr), .tx_buysell3(in_ord[3].bs), .tx_timestamp3(in_ord[3].ts), .tx_dv3(in_dv[3]),
      .tx_busy(tx_busy),
      .tx_addr(tx_addr), .tx_buysell(tx_buysell), .tx_timestamp(tx_timestamp), .tx_dv(tx_dv),
      .pending(pending), .grant(grant)
`ifdef TX_SCHED_DROPCNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] obs();
      return {9'd0, tx_dv, pending, grant, tx_addr, tx_buysell, tx_timestamp};
   endfunction

   function automatic logic [63:0] pack(input logic dv, input logic [3:0] p, input logic [1:0] g,
                                        input order_t o);
      return {9'd0, dv, p, g, o};
   endfunction

   function automatic logic [3:0] m_pend();
      logic [3:0] p;
      for (int n = 0; n < 4; n++) p[n] = m_valid[n];
      return p;
   endfunction

`ifdef TX_SCHED_DROPCNT_EN
   function automatic logic [DW-1:0] drop_of(input int n);
      return drop_cnt[n*DW +: DW];
   endfunction

   function automatic logic [4*DW-1:0] m_drop_vec();
      logic [4*DW-1:0] v;
      for (int n = 0; n < 4; n++) v[n*DW +: DW] = DW'(m_drop[n]);
      return v;
   endfunction
`endif

   task automatic model_reset();
      for (int n = 0; n < 4; n++) begin
         m_slot[n]  = '0;
         m_valid[n] = 1'b0;
         m_drop[n]  = 0;
      end
      m_rr = 0; m_mode = 0; m_wait = 0; m_grant = 0; m_dv = 1'b0; m_out = '0;
   endtask

   task automatic model_step();
      int pick;
      pick = -1;
      if (m_mode == 0 && !tx_busy)
         for (int k = 0; k < 4; k++)
            if (pick < 0 && m_valid[(m_rr + k) % 4]) pick = (m_rr + k) % 4;
      m_dv = (pick >= 0);
      case (m_mode)
         0: if (pick >= 0) begin m_mode = 1; m_wait = 0; end
         1: if (tx_busy) m_mode = 2;
            else begin
               m_wait++;
               if (m_wait == BW) m_mode = 0;
            end
         default: if (!tx_busy) m_mode = 0;
      endcase
      if (pick >= 0) begin
         m_out         = m_slot[pick];
         m_valid[pick] = 1'b0;
         m_grant       = pick;
         m_rr          = (pick + 1) % 4;
      end
      for (int n = 0; n < 4; n++)
         if (in_dv[n]) begin
            if (!m_valid[n]) begin
               m_slot[n]  = in_ord[n];
               m_valid[n] = 1'b1;
            end else if (m_drop[n] < DROP_MAX) begin
               m_drop[n]++;
            end
         end
   endtask

   task automatic tick();
      @(posedge clk);
      if (model_on) model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_dv   = '0;
      tx_busy = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic wait_dv(input string name, input int budget, output int n);
      n = 0;
      while (tx_dv !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      if (tx_dv !== 1'b1) check({name, "_wait"}, 64'(tx_dv), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      vec_t vecs[4];
      int   gap;
      bit   bad;

      vecs[0] = '{req: 1, ord: {8'h21, 8'h01, 32'h0000_1234}, exp_pend: 4'b0010, exp_grant: 2'd1};
      vecs[1] = '{req: 0, ord: {8'hFF, 8'h02, 32'hDEAD_BEEF}, exp_pend: 4'b0001, exp_grant: 2'd0};
      vecs[2] = '{req: 3, ord: {8'h00, 8'hFF, 32'hFFFF_FFFF}, exp_pend: 4'b1000, exp_grant: 2'd3};
      vecs[3] = '{req: 2, ord: {8'h80, 8'h7F, 32'h0000_0000}, exp_pend: 4'b0100, exp_grant: 2'd2};

      reset_n = 1'b0;
      tx_busy = 1'b0;
      in_dv   = '0;
      in_ord  = '0;
      u_rise  = 0;
      u_hold  = 0;
      model_reset();
      #12;
      check("reset_state", obs(), 64'd0);
`ifdef TX_SCHED_DROPCNT_EN
      check("reset_drop", 64'(drop_cnt), 64'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;

      // Single orders, one at a time, uart never answers busy.
      for (int i = 0; i < 4; i++) begin
         in_ord[vecs[i].req] = vecs[i].ord;
         in_dv[vecs[i].req]  = 1'b1;
         tick();
         in_dv = '0;
         check($sformatf("vec%0d_capture", i), 64'({tx_dv, pending}), 64'({1'b0, vecs[i].exp_pend}));
         tick();
         check($sformatf("vec%0d_issue", i), obs(), pack(1'b1, 4'b0, vecs[i].exp_grant, vecs[i].ord));
         tick();
         check($sformatf("vec%0d_hold", i), obs(), pack(1'b0, 4'b0, vecs[i].exp_grant, vecs[i].ord));
         repeat (BW - 1) tick();
      end

      // Contention: all four at once, uart busy for 10 cycles per order.
      do_reset();
      for (int n = 0; n < 4; n++) in_ord[n] = {8'(8'h10 + n), 8'(n), 32'(32'hC000_0000 + n)};
      in_dv = 4'hF;
      tick();
      in_dv = '0;
      check("contend_pending", 64'(pending), 64'hF);
      for (int k = 0; k < 4; k++) begin
         wait_dv($sformatf("contend%0d", k), 40, gap);
         check($sformatf("contend%0d_order", k), 64'({grant, tx_addr}), 64'({2'(k), 8'(8'h10 + k)}));
         check($sformatf("contend%0d_gap", k), 64'(gap), (k == 0) ? 64'd1 : 64'd2);
         tx_busy = 1'b1;
         bad     = 1'b0;
         repeat (10) begin
            tick();
            if (tx_dv) bad = 1'b1;
         end
         check($sformatf("contend%0d_quiet", k), 64'(bad), 64'd0);
         tx_busy = 1'b0;
      end
      check("contend_drained", 64'(pending), 64'd0);

      // Drop: second order to a full slot is discarded, the first survives.
      do_reset();
      tx_busy   = 1'b1;
      in_ord[2] = {8'h33, 8'h01, 32'h0000_0033};
      in_dv[2]  = 1'b1;
      tick();
      in_ord[2] = {8'h55, 8'h02, 32'h0000_0055};
      tick();
      in_dv = '0;
      check("drop_pending", 64'(pending), 64'h4);
`ifdef TX_SCHED_DROPCNT_EN
      check("drop_cnt_one", 64'(drop_of(2)), 64'd1);
`endif
      in_dv[2] = 1'b1;
      repeat (300) tick();
      in_dv = '0;
`ifdef TX_SCHED_DROPCNT_EN
      check("drop_cnt_sat", 64'(drop_of(2)), (301 > DROP_MAX) ? 64'(DROP_MAX) : 64'd301);
      check("drop_cnt_others", 64'({drop_of(3), drop_of(1), drop_of(0)}), 64'd0);
`endif
      tx_busy = 1'b0;
      wait_dv("drop_issue", 10, gap);
      check("drop_issue", obs(), pack(1'b1, 4'b0, 2'd2, {8'h33, 8'h01, 32'h0000_0033}));
      bad = 1'b0;
      repeat (BW + 4) begin
         tick();
         if (tx_dv) bad = 1'b1;
      end
      check("drop_no_second", 64'({bad, pending}), 64'd0);

      // Timeout: busy never rises, the next order follows after the wait window.
      do_reset();
      in_ord[0] = {8'hA0, 8'h10, 32'h0000_0001};
      in_ord[1] = {8'hA1, 8'h11, 32'h0000_0002};
      in_dv     = 4'b0011;
      tick();
      in_dv = '0;
      wait_dv("timeout_first", 5, gap);
      check("timeout_first", 64'({grant, tx_addr, pending}), 64'({2'd0, 8'hA0, 4'b0010}));
      tick();
      wait_dv("timeout_second", 20, gap);
      check("timeout_gap", 64'(gap + 1), 64'(BW + 1));
      check("timeout_second", obs(), pack(1'b1, 4'b0, 2'd1, {8'hA1, 8'h11, 32'h0000_0002}));

      // Reset while waiting for the uart with three orders queued.
      do_reset();
      for (int n = 0; n < 4; n++) in_ord[n] = {8'(8'hB0 + n), 8'hEE, 32'(n)};
      in_dv = 4'hF;
      tick();
      in_dv = '0;
      wait_dv("rst_issue", 5, gap);
      tx_busy  = 1'b1;
      in_dv[1] = 1'b1;
      tick();
      in_dv = '0;
      tick();
      check("rst_pre_pending", 64'(pending), 64'hE);
`ifdef TX_SCHED_DROPCNT_EN
      check("rst_pre_drop", 64'(drop_of(1)), 64'd1);
`endif
      #2 reset_n = 1'b0;
      #1;
      check("rst_async", obs(), 64'd0);
`ifdef TX_SCHED_DROPCNT_EN
      check("rst_async_drop", 64'(drop_cnt), 64'd0);
`endif
      tx_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      bad     = 1'b0;
      repeat (12) begin
         tick();
         if (tx_dv) bad = 1'b1;
      end
      check("rst_quiet", 64'({bad, pending}), 64'd0);

      // A new order arriving on the edge its slot is issued is kept without a drop.
      do_reset();
      in_ord[0] = {8'hC1, 8'h01, 32'h1111_0000};
      in_dv[0]  = 1'b1;
      tick();
      in_ord[0] = {8'hC2, 8'h02, 32'h2222_0000};
      tick();
      in_dv = '0;
      check("same_issue", obs(), pack(1'b1, 4'b0001, 2'd0, {8'hC1, 8'h01, 32'h1111_0000}));
`ifdef TX_SCHED_DROPCNT_EN
      check("same_no_drop", 64'(drop_of(0)), 64'd0);
`endif
      tick();
      wait_dv("same_second", 20, gap);
      check("same_gap", 64'(gap + 1), 64'(BW + 1));
      check("same_second", obs(), pack(1'b1, 4'b0, 2'd0, {8'hC2, 8'h02, 32'h2222_0000}));

      // Randomized traffic against the reference model.
      do_reset();
      u_rise   = 0;
      u_hold   = 0;
      model_on = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         check($sformatf("rand_c%0d", c), obs(), pack(m_dv, m_pend(), 2'(m_grant), m_out));
`ifdef TX_SCHED_DROPCNT_EN
         check($sformatf("rand_drop_c%0d", c), 64'(drop_cnt), 64'(m_drop_vec()));
`endif
         if (tx_dv) begin
            u_rise = $urandom_range(0, 6);
            u_hold = $urandom_range(1, 8);
         end
         if (u_rise > 0) begin
            tx_busy = 1'b0;
            u_rise--;
         end else if (u_hold > 0) begin
            tx_busy = 1'b1;
            u_hold--;
         end else begin
            tx_busy = 1'b0;
         end
         for (int n = 0; n < 4; n++) begin
            in_dv[n]     = ($urandom_range(0, 3) == 0);
            in_ord[n].addr = 8'($urandom);
            in_ord[n].bs   = 8'($urandom);
            in_ord[n].ts   = $urandom;
         end
         tick();
      end
      model_on = 1'b0;
      in_dv    = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 Parameter BUSY_WAIT, default 4: max cycles after tx_dv to wait for tx_busy to rise before treating the order as accepted.
REQ-002 Parameter DROP_W, default 8: width of each drop counter.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 tx_addrN  input  8  order address from system N, N=0..3.
REQ-006 tx_buysellN  input  8  buy/sell code from system N.
REQ-007 tx_timestampN  input  32  timestamp from system N.
REQ-008 tx_dvN  input  1  one-cycle valid pulse from system N.
REQ-009 tx_addr  output  8  order address to uart.
REQ-010 tx_buysell  output  8  buy/sell code to uart.
REQ-011 tx_timestamp  output  32  timestamp to uart.
REQ-012 tx_dv  output  1  one-cycle send pulse to uart.
REQ-013 tx_busy  input  1  uart transmitter busy.
REQ-014 pending  output  4  per-requester holding-slot valid bits.
REQ-015 grant  output  2  index of requester last issued.

Function
REQ-016 Each requester SHALL own a one-entry holding slot {addr, buysell, timestamp, valid}.
REQ-017 tx_dvN=1 with slot N empty: fields captured, valid=1 on that edge.
REQ-018 tx_dvN=1 with slot N full and not issued that cycle: new order dropped, old kept.
REQ-019 tx_dvN=1 on the cycle slot N is issued: new order captured, valid stays 1, no drop.
REQ-020 FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE, tx_busy=0, any pending: pick first valid slot at or after rr_ptr in order rr_ptr, rr_ptr+1, ... mod 4.
REQ-022 On that pick edge: load output fields from slot, tx_dv=1, clear slot valid, grant=index, rr_ptr=index+1 mod 4, go WAIT_BUSY.
REQ-023 tx_dv SHALL be high exactly one cycle per issue; output fields hold until next issue.
REQ-024 Latency: tx_dvN pulse at edge k, idle arbiter, tx_busy=0 -> tx_dv high after edge k+1.
REQ-025 IDLE with tx_busy=1 or nothing pending: stay IDLE, no issue.
REQ-026 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; else after BUSY_WAIT cycles without it -> IDLE.
REQ-027 WAIT_DONE: tx_busy=0 -> IDLE; stay otherwise, no timeout.
REQ-028 Round-robin SHALL guarantee any pending slot is issued within 4 issues.
REQ-029 Capture continues in every FSM state.
REQ-030 pending SHALL equal the slot valid bits registered (post-edge value).

Reset
REQ-031 reset_n=0 SHALL immediately clear all slots, tx_dv=0, output fields=0, pending=0, grant=0, rr_ptr=0, FSM=IDLE, drop counters=0.
REQ-032 Reset mid-transfer SHALL discard all pending orders; no tx_dv until new requests arrive after release.
REQ-033 First edge after release SHALL behave as normal IDLE.

Configuration
REQ-034 Macro TX_SCHED_DROPCNT_EN defined: output drop_cnt, 4*DROP_W bits, per-requester counter N at bits [N*DROP_W +: DROP_W], +1 per REQ-018 drop, saturating at all-ones.
REQ-035 Macro undefined: no drop_cnt port, no counter logic; drops silent, all else identical.

Verification
REQ-036 Single: tx_dv1 pulse addr=0x21 buysell=0x01 ts=0x0000_1234, busy=0 -> tx_dv one cycle after, outputs match, grant=1, pending=0.
REQ-037 Contention: tx_dv0..3 same cycle, uart busy 10 cycles per order -> issue order 0,1,2,3, each tx_dv only after tx_busy falls.
REQ-038 Drop: two tx_dv2 pulses while busy=1, second addr=0x55 -> issues first order only; drop_cnt[2]=1 with macro, 255 after 300 drops (saturate).
REQ-039 Timeout: busy never rises, BUSY_WAIT=4 -> FSM back to IDLE after 4 cycles, next pending order issued.
REQ-040 Reset: reset_n low in WAIT_DONE with 3 pending -> outputs 0 immediately, no tx_dv after release until new request.
REQ-041 Same-cycle capture/issue: tx_dv0 again on slot 0 issue edge -> no drop, pending[0]=1, second order issued next.
